// File: rtl/conn_bus_responder_pkg.sv
// Shared definitions for the connector bus responder: default geometry and FSM state encoding.
// Latency: none, declarations only.
// Backpressure: not applicable.
package conn_bus_responder_pkg;

  localparam int unsigned DEF_AW   = 8;
  localparam int unsigned DEF_DW   = 16;
  localparam int unsigned DEF_BASE = 32'h40;
  localparam int unsigned DEF_NREG = 4;
  localparam int unsigned DEF_SYNC = 2;

  typedef enum logic [2:0] {
    ST_SETTLE,   // waiting for the strobe to be seen released after reset
    ST_IDLE,     // waiting for a new strobe
    ST_DECODE,   // address/data sampled, response registered on exit
    ST_ACK,      // single-cycle acknowledge, write strobe visible
    ST_HOLD,     // DTACK held until strobe release
    ST_IGNORE    // address miss, wait for strobe release
  } state_e;

endpackage

// File: rtl/conn_sync.sv
// N-stage flip-flop synchroniser for a single asynchronous bit, with selectable reset value.
// Latency: STAGES rising edges from input change to output change.
// Backpressure: none, free-running.
// Ports: clk/rst_n (async active-low clear to RST_VAL), d (async input), q (synchronised output).
module conn_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/conn_bus_responder.sv
// Board-side responder for the strobed connector register bus: RW register bank plus a status word.
// Latency: DTACK_N falls SYNC_STAGES+2 edges after AS_N is first seen low, rises SYNC_STAGES+1 edges after release.
// Backpressure: none; a strobe that never releases parks the FSM in HOLD/IGNORE until it does.
// Ports: CLK/RESET_N; BUS_AS_N, BUS_WR_N, BUS_ADDR, BUS_DIN from the connector; BUS_DOUT, BUS_DOE,
//        BUS_DTACK_N to the connector; REG_Q (flattened registers), WR_STB/WR_IDX write notify, STATUS_IN.
module conn_bus_responder
  import conn_bus_responder_pkg::*;
#(
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned BASE        = DEF_BASE,
  parameter int unsigned NREG        = DEF_NREG,
  parameter int unsigned SYNC_STAGES = DEF_SYNC
) (
  input  logic                                   CLK,
  input  logic                                   RESET_N,
  input  logic                                   BUS_AS_N,
  input  logic                                   BUS_WR_N,
  input  logic [AW-1:0]                          BUS_ADDR,
  input  logic [DW-1:0]                          BUS_DIN,
  output logic [DW-1:0]                          BUS_DOUT,
  output logic                                   BUS_DOE,
  output logic                                   BUS_DTACK_N,
  output logic [NREG*DW-1:0]                     REG_Q,
  output logic                                   WR_STB,
  output logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] WR_IDX,
  input  logic [DW-1:0]                          STATUS_IN
);

  localparam int unsigned IW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW-1:0] BASE_A = AW'(BASE);
  localparam logic [AW-1:0] LAST_A = AW'(BASE + NREG);   // status word address

  // The decoded window must not wrap past the top of the address space.
  if ((64'(BASE) + 64'(NREG)) >= (64'd1 << AW)) begin : g_bad_window
    $error("conn_bus_responder: BASE+NREG does not fit in AW bits");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("conn_bus_responder: SYNC_STAGES must be at least 2");
  end

  // Strobe synchroniser resets asserted so a strobe held through reset is not a new cycle.
  logic as_s;
  conn_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_as_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (BUS_AS_N),
    .q     (as_s)
  );

  state_e                   state_q,   state_d;
  logic [NREG-1:0][DW-1:0]  reg_q,     reg_d;
  logic [DW-1:0]            dout_q,    dout_d;
  logic                     doe_q,     doe_d;
  logic                     dtack_n_q, dtack_n_d;
  logic                     wr_stb_q,  wr_stb_d;
  logic [IW-1:0]            wr_idx_q,  wr_idx_d;

  logic          hit;
  logic          is_status;
  logic [IW-1:0] idx;

  assign hit       = (BUS_ADDR >= BASE_A) && (BUS_ADDR <= LAST_A);
  assign is_status = (BUS_ADDR == LAST_A);
  assign idx       = IW'(BUS_ADDR - BASE_A);

  // Address, direction and data are sampled in DECODE and the complete response is
  // registered on the DECODE->ACK edge, so the ACK cycle already presents DTACK,
  // read data and the write strobe without an extra pipeline stage.
  always_comb begin
    state_d   = state_q;
    reg_d     = reg_q;
    dout_d    = dout_q;
    doe_d     = doe_q;
    dtack_n_d = dtack_n_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    case (state_q)
      ST_SETTLE: if (as_s) state_d = ST_IDLE;
      ST_IDLE:   if (!as_s) state_d = ST_DECODE;
      ST_DECODE: begin
        if (hit) begin
          state_d   = ST_ACK;
          dtack_n_d = 1'b0;
          if (!BUS_WR_N) begin
            // Writes to the status address are acknowledged but dropped.
            if (!is_status) begin
              reg_d[idx] = BUS_DIN;
              wr_stb_d   = 1'b1;
              wr_idx_d   = idx;
            end
          end else begin
            dout_d = is_status ? STATUS_IN : reg_q[idx];
            doe_d  = 1'b1;
          end
        end else begin
          state_d = ST_IGNORE;
        end
      end
      ST_ACK:    state_d = ST_HOLD;
      ST_HOLD: begin
        if (as_s) begin
          state_d   = ST_IDLE;
          dtack_n_d = 1'b1;
          doe_d     = 1'b0;   // DOUT deliberately left as-is
        end
      end
      ST_IGNORE: if (as_s) state_d = ST_IDLE;
      default:   state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_SETTLE;
      reg_q     <= '0;
      dout_q    <= '0;
      doe_q     <= 1'b0;
      dtack_n_q <= 1'b1;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      reg_q     <= reg_d;
      dout_q    <= dout_d;
      doe_q     <= doe_d;
      dtack_n_q <= dtack_n_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  assign BUS_DOUT    = dout_q;
  assign BUS_DOE     = doe_q;
  assign BUS_DTACK_N = dtack_n_q;
  assign REG_Q       = reg_q;
  assign WR_STB      = wr_stb_q;
  assign WR_IDX      = wr_idx_q;

endmodule

// File: tb/tb_conn_bus_responder.sv
// Self-checking bench for conn_bus_responder: directed cases then random cycles against a register-array model.
// Latency: n/a.
// Backpressure: n/a.
module tb_conn_bus_responder;

  localparam int SYNC = 2;
  localparam int BASE = 'h40;
  localparam int NREG = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        BUS_AS_N;
  logic        BUS_WR_N;
  logic [7:0]  BUS_ADDR;
  logic [15:0] BUS_DIN;
  logic [15:0] BUS_DOUT;
  logic        BUS_DOE;
  logic        BUS_DTACK_N;
  logic [63:0] REG_Q;
  logic        WR_STB;
  logic [1:0]  WR_IDX;
  logic [15:0] STATUS_IN;

  conn_bus_responder #(
    .AW(8), .DW(16), .BASE(BASE), .NREG(NREG), .SYNC_STAGES(SYNC)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BUS_AS_N(BUS_AS_N), .BUS_WR_N(BUS_WR_N),
    .BUS_ADDR(BUS_ADDR), .BUS_DIN(BUS_DIN), .BUS_DOUT(BUS_DOUT), .BUS_DOE(BUS_DOE),
    .BUS_DTACK_N(BUS_DTACK_N), .REG_Q(REG_Q), .WR_STB(WR_STB), .WR_IDX(WR_IDX),
    .STATUS_IN(STATUS_IN)
  );

  always #5 CLK = ~CLK;

  typedef struct { bit rd; logic [15:0] data; } ack_t;
  typedef struct { int idx; logic [15:0] data; } wr_t;

  ack_t        exp_ack[$];
  wr_t         exp_wr[$];
  logic [15:0] model_reg [NREG];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < NREG; i++) f[i*16 +: 16] = model_reg[i];
    return f;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT acknowledges or strobes a write.
  initial begin
    logic prev_dtack_n;
    ack_t a;
    wr_t  w;
    prev_dtack_n = 1'b1;
    forever begin
      @(negedge CLK);
      if (RESET_N === 1'b1) begin
        if (prev_dtack_n === 1'b1 && BUS_DTACK_N === 1'b0) begin
          if (exp_ack.size() == 0) check("unexpected_dtack", 1, 0);
          else begin
            a = exp_ack.pop_front();
            check("ack_doe", 64'(BUS_DOE), 64'(a.rd));
            if (a.rd) check("ack_dout", 64'(BUS_DOUT), 64'(a.data));
          end
        end
        if (WR_STB !== 1'b0) begin
          if (exp_wr.size() == 0) check("unexpected_wr_stb", 64'(WR_STB), 0);
          else begin
            w = exp_wr.pop_front();
            check("wr_idx", 64'(WR_IDX), 64'(w.idx));
            check("wr_reg", 64'(REG_Q[w.idx*16 +: 16]), 64'(w.data));
          end
        end
      end
      prev_dtack_n = BUS_DTACK_N;
    end
  end

  // One complete bus cycle: model predicts the response, then strobe is held for 'hold' edges.
  task automatic bus_cycle(input logic [7:0] addr, input logic wr_n, input logic [15:0] din, input int hold);
    bit          hit, is_stat, saw_doe;
    int          fall_at, rise_at, off;
    logic [15:0] rdata;
    ack_t        a;
    wr_t         w;
    off     = int'(addr) - BASE;
    hit     = (off >= 0) && (off <= NREG);
    is_stat = (off == NREG);
    rdata   = '0;
    if (hit) begin
      if (wr_n) rdata = is_stat ? STATUS_IN : model_reg[off];
      else if (!is_stat) begin
        model_reg[off] = din;
        w.idx = off; w.data = din;
        exp_wr.push_back(w);
      end
      a.rd = wr_n; a.data = rdata;
      exp_ack.push_back(a);
    end
    @(negedge CLK);
    BUS_ADDR = addr; BUS_WR_N = wr_n; BUS_DIN = din; BUS_AS_N = 1'b0;
    fall_at = 0; saw_doe = 0;
    for (int e = 1; e <= hold; e++) begin
      @(posedge CLK); #1;
      if (BUS_DOE !== 1'b0) saw_doe = 1;
      if (fall_at == 0 && BUS_DTACK_N === 1'b0) fall_at = e;
    end
    check("dtack_fall_edge", 64'(fall_at), hit ? 64'(SYNC + 2) : 64'd0);
    if (!hit || !wr_n) check("doe_quiet", 64'(saw_doe), 0);
    @(negedge CLK);
    BUS_AS_N = 1'b1;
    if (hit) begin
      rise_at = 0;
      for (int e = 1; e <= 10; e++) begin
        @(posedge CLK); #1;
        if (BUS_DTACK_N === 1'b1) begin rise_at = e; break; end
      end
      check("dtack_rise_edge", 64'(rise_at), 64'(SYNC + 1));
      check("doe_after_release", 64'(BUS_DOE), 0);
      if (wr_n) check("dout_held", 64'(BUS_DOUT), 64'(rdata));
    end else begin
      repeat (SYNC + 1) @(posedge CLK);
      #1;
    end
    check("regq_model", REG_Q, model_flat());
  endtask

  initial begin
    int fall_at, quiet_bad;
    ack_t a;
    for (int i = 0; i < NREG; i++) model_reg[i] = '0;
    RESET_N = 1'b0; BUS_AS_N = 1'b1; BUS_WR_N = 1'b1;
    BUS_ADDR = '0; BUS_DIN = '0; STATUS_IN = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_dout", 64'(BUS_DOUT), 0);
    check("rst_doe", 64'(BUS_DOE), 0);
    check("rst_dtack_n", 64'(BUS_DTACK_N), 1);
    check("rst_regq", REG_Q, 0);
    check("rst_wr_stb", 64'(WR_STB), 0);
    check("rst_wr_idx", 64'(WR_IDX), 0);
    @(negedge CLK) RESET_N = 1'b1;
    repeat (5) @(posedge CLK);

    // Basic write then read-back.
    bus_cycle(8'h42, 1'b0, 16'hBEEF, 4);
    bus_cycle(8'h42, 1'b1, 16'h0000, 4);

    // Status word: read returns STATUS_IN, write is acknowledged and discarded.
    STATUS_IN = 16'h1234;
    bus_cycle(8'h44, 1'b1, 16'h0000, 4);
    bus_cycle(8'h44, 1'b0, 16'hFFFF, 4);

    // Misses on both sides of the window, strobe held long.
    bus_cycle(8'h3F, 1'b0, 16'hAAAA, 20);
    bus_cycle(8'h45, 1'b1, 16'h0000, 20);
    bus_cycle(8'h41, 1'b0, 16'h5A5A, 4);

    // Reset in HOLD with strobe low.
    a.rd = 1'b1; a.data = model_reg[1];
    exp_ack.push_back(a);
    @(negedge CLK);
    BUS_ADDR = 8'h41; BUS_WR_N = 1'b1; BUS_AS_N = 1'b0;
    fall_at = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge CLK); #1;
      if (BUS_DTACK_N === 1'b0) begin fall_at = e; break; end
    end
    check("pre_reset_ack", 64'(fall_at), 64'(SYNC + 2));
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    #1;
    check("midrst_dtack_n", 64'(BUS_DTACK_N), 1);
    check("midrst_doe", 64'(BUS_DOE), 0);
    check("midrst_regq", REG_Q, 0);
    for (int i = 0; i < NREG; i++) model_reg[i] = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESET_N = 1'b1;
    quiet_bad = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (BUS_DTACK_N !== 1'b1 || BUS_DOE !== 1'b0) quiet_bad++;
    end
    check("held_strobe_after_reset", 64'(quiet_bad), 0);
    @(negedge CLK) BUS_AS_N = 1'b1;
    repeat (4) @(posedge CLK);
    bus_cycle(8'h43, 1'b1, 16'h0000, 4);
    bus_cycle(8'h43, 1'b0, 16'hC0DE, 4);
    bus_cycle(8'h43, 1'b1, 16'h0000, 4);

    // Back-to-back writes with minimum strobe-high time, then read all back.
    for (int i = 0; i < NREG; i++) bus_cycle(8'(BASE + i), 1'b0, 16'(i + 1), 4);
    for (int i = 0; i < NREG; i++) bus_cycle(8'(BASE + i), 1'b1, 16'h0000, 4);

    // Random traffic across and around the window.
    for (int n = 0; n < 80; n++) begin
      STATUS_IN = 16'($urandom);
      bus_cycle(8'($urandom_range(70, 62)), 1'($urandom_range(1, 0)),
                16'($urandom), 4 + $urandom_range(3, 0));
    end

    repeat (4) @(posedge CLK);
    check("ack_queue_drained", 64'(exp_ack.size()), 0);
    check("wr_queue_drained", 64'(exp_wr.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conn_bus_responder.md
Name: conn_bus_responder

Overview:
- Board-side responder for the strobed register bus carried across the 165-pin inter-board connector.
- The crate controller initiates each cycle with an address strobe. This block synchronises the strobes, decodes the address and completes the read or write.
- A read returns data and a DTACK handshake on the connector pins.
- Holds a small RW register bank plus one read-only status word for the local board logic.

Parameters:
- AW, 8, bus address width.
- DW, 16, bus data width.
- BASE, 8'h40, first decoded address.
- NREG, 4, number of RW registers at BASE..BASE+NREG-1; the status word sits at BASE+NREG.
- SYNC_STAGES, 2, flip-flop depth of the strobe synchronisers (minimum 2).

Ports:
- CLK, in, 1, board clock.
- RESET_N, in, 1, asynchronous active-low reset.
- BUS_AS_N, in, 1, address strobe from connector; asynchronous, active low.
- BUS_WR_N, in, 1, 0 = write, 1 = read; valid while AS_N is low.
- BUS_ADDR, in, AW, address; stable from before AS_N falls until AS_N rises.
- BUS_DIN, in, DW, write data from connector; same stability as BUS_ADDR.
- BUS_DOUT, out, DW, read data to connector pads.
- BUS_DOE, out, 1, pad output enable for BUS_DOUT.
- BUS_DTACK_N, out, 1, data acknowledge, active low.
- REG_Q, out, NREG*DW, flattened RW register contents; register i is at bits [i*DW +: DW].
- WR_STB, out, 1, one-cycle pulse when a RW register is written.
- WR_IDX, out, clog2(NREG), index of the register written; valid with WR_STB.
- STATUS_IN, in, DW, local status, readable at BASE+NREG.

Behaviour:
- Reset values: BUS_DOUT=0, BUS_DOE=0, BUS_DTACK_N=1, REG_Q=0, WR_STB=0, WR_IDX=0, FSM=SETTLE.
- Reset takes effect immediately and asynchronously on all outputs, including during a transaction.
- Strobe synchroniser:
  - SYNC_STAGES flops on BUS_AS_N; as_s denotes the synchronised value.
  - The flops reset to 0 (asserted), so a strobe held low through reset is never taken as a new cycle.
- BUS_ADDR, BUS_WR_N and BUS_DIN are sampled only in DECODE; the protocol guarantees they are stable by then. They are not synchronised.
- Hit condition: BASE <= addr <= BASE+NREG, evaluated in AW-bit unsigned arithmetic with no wrap. BASE+NREG must be < 2^AW; this is checked by an elaboration-time assertion.
- FSM states and transitions:
  - SETTLE: wait for as_s=1, then go to IDLE.
  - IDLE: if as_s=0, go to DECODE.
  - DECODE: latch addr, wr_n and din.
    - Hit: go to ACK.
    - Miss: go to IGNORE.
  - ACK: lasts exactly 1 cycle.
    - Write to RW register: update REG_Q[idx] from din; pulse WR_STB with WR_IDX=idx.
    - Write to the status address: acknowledged; data discarded; no WR_STB.
    - Read: BUS_DOUT = REG_Q[idx], or STATUS_IN for the status address, captured this cycle; BUS_DOE=1.
    - BUS_DTACK_N=0 in all cases. Go to HOLD.
  - HOLD: keep DTACK_N=0 and keep DOE and DOUT stable until as_s=1.
    - Then DTACK_N=1, DOE=0, DOUT unchanged, and go to IDLE.
  - IGNORE: drive nothing (DOE=0, DTACK_N=1). On as_s=1, go to IDLE. The controller times out on its own side.
- Latency: DTACK_N falls SYNC_STAGES+2 rising edges after the first edge that sees BUS_AS_N low.
  - DTACK_N rises SYNC_STAGES+1 edges after BUS_AS_N rises.
- Back-to-back cycles: a new cycle requires as_s to return to 1 first. A strobe that never releases holds the FSM in HOLD or IGNORE indefinitely; this is legal.
- A glitch on AS_N shorter than one clock may be missed. Any such glitch that is captured must pass through DECODE and HOLD/IGNORE cleanly; no partial writes are allowed.
- STATUS_IN is sampled once, in ACK. It is not resynchronised here; the local logic provides it in the CLK domain.
- All registers are on CLK with asynchronous clear on RESET_N.

Decomposition:
- Shared package:
  - state encoding: SETTLE, IDLE, DECODE, ACK, HOLD, IGNORE;
  - default BASE, AW, DW.
- Sub-module: conn_sync, an N-stage synchroniser with parameterised reset value, instantiated for BUS_AS_N.

Test Plan:
- Write: ADDR=8'h42, DIN=16'hBEEF, WR_N=0, AS_N low -> DTACK_N=0 after 4 edges; REG_Q[2]=16'hBEEF; one WR_STB with WR_IDX=2; DOE stays 0.
- Read: ADDR=8'h42 after the previous write, WR_N=1 -> DOUT=16'hBEEF, DOE=1, DTACK_N=0. Release AS_N -> DTACK_N=1 and DOE=0 after 3 edges.
- Status: STATUS_IN=16'h1234.
  - Read 8'h44 -> DOUT=16'h1234.
  - Write 8'h44 with 16'hFFFF -> DTACK returned, no WR_STB, REG_Q unchanged.
- Miss: ADDR=8'h3F and separately 8'h45, AS_N held low for 20 cycles -> DTACK_N stays 1, DOE stays 0, no WR_STB; the next valid cycle completes normally.
- Reset mid-cycle: assert RESET_N=0 while in HOLD with AS_N low -> DTACK_N=1 and DOE=0 immediately.
  - Release reset with AS_N still low -> no response.
  - Raise AS_N, then start a fresh read -> it completes normally.
- Back-to-back: write regs 0..3 with 16'h0001..16'h0004 using minimum AS_N high time -> 4 WR_STB pulses in order, and all registers read back correctly.
